// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu_if
// Description : Data-memory request/response bundle used by the MEM stage.
//               The LSU drives the request side (master); the memory drives
//               ready and the response (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_lsu_if #(
  parameter int XLEN = 32
);
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_req_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN/8-1:0] dmem_wstrb;
  logic              dmem_rsp_valid;
  logic [XLEN-1:0]   dmem_rsp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : Pipeline MEM stage. Issues sized loads/stores over a
//               valid/ready request + response channel, stalls upstream while
//               an access is outstanding, and holds the MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   memPc,
  input  logic [XLEN-1:0]   memAluRes,
  input  logic [XLEN-1:0]   memRegData2,
  input  logic [4:0]        memRd,
  input  logic [CTRL_W-1:0] memCtrlSig,
  output logic              memStall,
  mem_stage_lsu_if.master   dmem,
  output logic [XLEN-1:0]   wbPc,
  output logic [XLEN-1:0]   wbResult,
  output logic [4:0]        wbRd,
  output logic [CTRL_W-1:0] wbCtrlSig,
  output logic              wbValid,
  output logic              wbMisalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  // control decode
  logic       mem_read, mem_write, unsigned_load, is_mem, bubble, misalign;
  logic [1:0] size;
  logic [1:0] byte_off;

  assign mem_read      = memCtrlSig[2];
  assign mem_write     = memCtrlSig[3];
  assign size          = memCtrlSig[5:4];
  assign unsigned_load = memCtrlSig[6];
  assign is_mem        = mem_read | mem_write;
  assign bubble        = (memCtrlSig == '0);
  assign byte_off      = memAluRes[1:0];
  // size 2'b11 is reserved and handled as a word access
  assign misalign      = is_mem && (((size == 2'b01) && byte_off[0]) ||
                                    (size[1] && (byte_off != 2'b00)));

  // store lane replication, strobes and load extraction
  logic [XLEN-1:0] store_data, shifted, load_data;
  logic [3:0]      store_strb;

  // build write data/strobes and the sign/zero-extended load value
  always_comb begin
    store_data = memRegData2;
    store_strb = 4'hF;
    shifted    = dmem.dmem_rsp_rdata >> {byte_off, 3'b000};
    load_data  = shifted;
    case (size)
      2'b00: begin
        store_data = {4{memRegData2[7:0]}};
        store_strb = 4'b0001 << byte_off;
        load_data  = unsigned_load ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        store_data = {2{memRegData2[15:0]}};
        store_strb = 4'b0011 << {byte_off[1], 1'b0};
        load_data  = unsigned_load ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        store_data = memRegData2;
        store_strb = 4'hF;
        load_data  = shifted;
      end
    endcase
  end

  // request channel is driven straight from the held EX/MEM inputs
  assign dmem.dmem_req_valid = (state == REQ);
  assign dmem.dmem_req_we    = mem_write;
  assign dmem.dmem_addr      = {memAluRes[XLEN-1:2], 2'b00};
  assign dmem.dmem_wdata     = store_data;
  assign dmem.dmem_wstrb     = mem_write ? store_strb : 4'h0;

  // MEM/WB next values; anything not explicitly loaded is a bubble
  logic [XLEN-1:0]   pc_nxt, result_nxt;
  logic [4:0]        rd_nxt;
  logic [CTRL_W-1:0] ctrl_nxt;
  logic              valid_nxt, misalign_nxt;

  // next-state, stall and MEM/WB load selection
  always_comb begin
    state_nxt    = state;
    memStall     = 1'b0;
    pc_nxt       = '0;
    result_nxt   = '0;
    rd_nxt       = '0;
    ctrl_nxt     = '0;
    valid_nxt    = 1'b0;
    misalign_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem && !misalign) begin
          memStall  = 1'b1;
          state_nxt = REQ;
        end else begin
          // non-memory op, bubble, or a misaligned access that is retired
          // without touching memory and with regWrite suppressed
          pc_nxt       = memPc;
          result_nxt   = memAluRes;
          rd_nxt       = memRd;
          ctrl_nxt     = misalign ? {memCtrlSig[CTRL_W-1:1], 1'b0} : memCtrlSig;
          valid_nxt    = !bubble;
          misalign_nxt = misalign;
        end
      end
      REQ: begin
        memStall = 1'b1;
        if (dmem.dmem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (dmem.dmem_rsp_valid) begin
          state_nxt  = IDLE;
          pc_nxt     = memPc;
          result_nxt = mem_read ? load_data : memAluRes;
          rd_nxt     = memRd;
          ctrl_nxt   = memCtrlSig;
          valid_nxt  = 1'b1;
        end else begin
          memStall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbPc       <= '0;
      wbResult   <= '0;
      wbRd       <= '0;
      wbCtrlSig  <= '0;
      wbValid    <= 1'b0;
      wbMisalign <= 1'b0;
    end else begin
      wbPc       <= pc_nxt;
      wbResult   <= result_nxt;
      wbRd       <= rd_nxt;
      wbCtrlSig  <= ctrl_nxt;
      wbValid    <= valid_nxt;
      wbMisalign <= misalign_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu. Expected MEM/WB
//               contents are queued when an instruction is presented and
//               compared when wbValid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] memPc, memAluRes, memRegData2;
  logic [4:0]  memRd;
  logic [9:0]  memCtrlSig;
  logic        memStall;
  logic [31:0] wbPc, wbResult;
  logic [4:0]  wbRd;
  logic [9:0]  wbCtrlSig;
  logic        wbValid, wbMisalign;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  rd;
    logic [9:0]  ctrl;
    logic        misalign;
    logic        has_res;
    int          when;
  } exp_t;

  exp_t sb[$];

  mem_stage_lsu_if #(.XLEN(32)) dmem ();

  mem_stage_lsu #(.XLEN(32), .CTRL_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .memPc       (memPc),
    .memAluRes   (memAluRes),
    .memRegData2 (memRegData2),
    .memRd       (memRd),
    .memCtrlSig  (memCtrlSig),
    .memStall    (memStall),
    .dmem        (dmem.master),
    .wbPc        (wbPc),
    .wbResult    (wbResult),
    .wbRd        (wbRd),
    .wbCtrlSig   (wbCtrlSig),
    .wbValid     (wbValid),
    .wbMisalign  (wbMisalign)
  );

  always #5 clk = ~clk;

  // cycle counter used for latency expectations
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, alu, rd2, input logic [4:0] rd, input logic [9:0] ctrl);
    memPc = pc; memAluRes = alu; memRegData2 = rd2; memRd = rd; memCtrlSig = ctrl;
  endtask

  task automatic drive_bubble();
    drive(32'h0, 32'h0, 32'h0, 5'd0, 10'h0);
  endtask

  // scoreboard consumer: every valid WB entry must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && wbValid) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", {31'h0, wbValid}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_pc", wbPc, e.pc);
        check("wb_rd", {27'h0, wbRd}, {27'h0, e.rd});
        check("wb_ctrl", {22'h0, wbCtrlSig}, {22'h0, e.ctrl});
        check("wb_misalign", {31'h0, wbMisalign}, {31'h0, e.misalign});
        check("wb_latency", cyc, e.when);
        if (e.has_res) check("wb_result", wbResult, e.result);
      end
    end
  end

  logic [31:0] next_pc = 32'h1000;

  task automatic alu_op(input logic [31:0] result, input logic [4:0] rd, input logic [9:0] ctrl);
    exp_t e;
    drive(next_pc, result, 32'h5555_AAAA, rd, ctrl);
    e = '{pc: next_pc, result: result, rd: rd, ctrl: ctrl, misalign: 1'b0, has_res: 1'b1, when: cyc + 1};
    sb.push_back(e);
    next_pc += 4;
    @(negedge clk);
    check("alu_stall", {31'h0, memStall}, 32'h0);
    check("alu_req_valid", {31'h0, dmem.dmem_req_valid}, 32'h0);
    step();
  endtask

  task automatic misalign_op(input logic [31:0] addr, input logic [9:0] ctrl);
    exp_t e;
    drive(next_pc, addr, 32'h0, 5'd9, ctrl);
    e = '{pc: next_pc, result: 32'h0, rd: 5'd9, ctrl: {ctrl[9:1], 1'b0}, misalign: 1'b1, has_res: 1'b0, when: cyc + 1};
    sb.push_back(e);
    next_pc += 4;
    @(negedge clk);
    check("mis_stall", {31'h0, memStall}, 32'h0);
    check("mis_req_valid", {31'h0, dmem.dmem_req_valid}, 32'h0);
    step();
    drive_bubble();
  endtask

  task automatic check_req(input logic [31:0] addr, input logic we, input logic [3:0] strb, input logic [31:0] wdata);
    check("req_valid", {31'h0, dmem.dmem_req_valid}, 32'h1);
    check("req_stall", {31'h0, memStall}, 32'h1);
    check("req_addr", dmem.dmem_addr, {addr[31:2], 2'b00});
    check("req_we", {31'h0, dmem.dmem_req_we}, {31'h0, we});
    check("req_wstrb", {28'h0, dmem.dmem_wstrb}, {28'h0, strb});
    if (we) check("req_wdata", dmem.dmem_wdata, wdata);
  endtask

  // full memory transaction; called right after a clock edge in IDLE
  task automatic mem_op(input logic [31:0] addr, rd2, input logic [9:0] ctrl,
                        input logic [31:0] rdata, input int rdy_dly, rsp_dly,
                        input logic [31:0] exp_res, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata);
    exp_t e;
    drive(next_pc, addr, rd2, 5'd7, ctrl);
    e = '{pc: next_pc, result: exp_res, rd: 5'd7, ctrl: ctrl, misalign: 1'b0, has_res: 1'b1,
          when: cyc + 3 + rdy_dly + rsp_dly};
    sb.push_back(e);
    next_pc += 4;
    @(negedge clk);
    check("idle_stall", {31'h0, memStall}, 32'h1);
    check("idle_req_valid", {31'h0, dmem.dmem_req_valid}, 32'h0);
    step();
    for (int i = 0; i < rdy_dly; i++) begin
      dmem.dmem_rsp_valid = 1'b1;          // stray response while still in REQ
      dmem.dmem_rsp_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      check_req(addr, ctrl[3], exp_strb, exp_wdata);
      step();
    end
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_req_ready = 1'b1;
    @(negedge clk);
    check_req(addr, ctrl[3], exp_strb, exp_wdata);
    step();
    dmem.dmem_req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      @(negedge clk);
      check("wait_stall", {31'h0, memStall}, 32'h1);
      check("wait_req_valid", {31'h0, dmem.dmem_req_valid}, 32'h0);
      step();
    end
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rsp_rdata = rdata;
    @(negedge clk);
    check("rsp_stall", {31'h0, memStall}, 32'h0);
    step();
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rsp_rdata = 32'h0;
    drive_bubble();
  endtask

  initial begin
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rsp_rdata = 32'h0;
    drive_bubble();

    // reset state
    @(negedge clk);
    check("rst_req_valid", {31'h0, dmem.dmem_req_valid}, 32'h0);
    check("rst_wb_valid", {31'h0, wbValid}, 32'h0);
    check("rst_wb_result", wbResult, 32'h0);
    check("rst_wb_misalign", {31'h0, wbMisalign}, 32'h0);
    #2 rst_n = 1'b1;
    step();

    // non-memory ops, including upper control bits passed through
    alu_op(32'h0000_0042, 5'd3, 10'h001);
    alu_op(32'h1234_5678, 5'd4, 10'h381);
    drive_bubble();
    step();

    // lw, immediate ready and response
    mem_op(32'h104, 32'h0, 10'h027, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 4'h0, 32'h0);
    // lb / lbu at byte 3
    mem_op(32'h103, 32'h0, 10'h007, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 4'h0, 32'h0);
    mem_op(32'h103, 32'h0, 10'h047, 32'h80FF_1234, 0, 0, 32'h0000_0080, 4'h0, 32'h0);
    // lh / lhu at upper half
    mem_op(32'h102, 32'h0, 10'h017, 32'h80FF_1234, 0, 1, 32'hFFFF_80FF, 4'h0, 32'h0);
    mem_op(32'h102, 32'h0, 10'h057, 32'h80FF_1234, 0, 0, 32'h0000_80FF, 4'h0, 32'h0);
    // stores: sh, sb, sw
    mem_op(32'h202, 32'h0000_ABCD, 10'h018, 32'h0, 0, 0, 32'h0000_0202, 4'b1100, 32'hABCD_ABCD);
    mem_op(32'h201, 32'h1234_5678, 10'h008, 32'h0, 0, 2, 32'h0000_0201, 4'b0010, 32'h7878_7878);
    mem_op(32'h300, 32'hCAFE_F00D, 10'h028, 32'h0, 1, 0, 32'h0000_0300, 4'hF, 32'hCAFE_F00D);
    // ready held low for 4 cycles with stray responses in REQ
    mem_op(32'h108, 32'h0, 10'h027, 32'h1122_3344, 4, 1, 32'h1122_3344, 4'h0, 32'h0);

    // misaligned lw and lh
    misalign_op(32'h101, 10'h027);
    misalign_op(32'h105, 10'h017);
    step();

    // reset while waiting for a response
    drive(32'h2000, 32'h104, 32'h0, 5'd5, 10'h027);
    step();                               // REQ
    dmem.dmem_req_ready = 1'b1;
    step();                               // WAIT
    dmem.dmem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_req_valid", {31'h0, dmem.dmem_req_valid}, 32'h0);
    check("arst_wb_valid", {31'h0, wbValid}, 32'h0);
    check("arst_wb_pc", wbPc, 32'h0);
    check("arst_wb_rd", {27'h0, wbRd}, 32'h0);
    drive_bubble();
    step();
    #3 rst_n = 1'b1;
    step();
    dmem.dmem_rsp_valid = 1'b1;           // late response after reset
    dmem.dmem_rsp_rdata = 32'hFEED_FACE;
    @(negedge clk);
    check("late_rsp_stall", {31'h0, memStall}, 32'h0);
    step();
    dmem.dmem_rsp_valid = 1'b0;
    alu_op(32'h0000_0099, 5'd6, 10'h001);
    drive_bubble();
    repeat (3) step();

    check("sb_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage that consumes the EX/MEM pipeline register outputs (PC, ALU result, store data, rd, 10-bit control).
- Performs loads and stores over a valid/ready request and response interface to data memory.
- Contains the MEM/WB pipeline register and stalls upstream while an access is outstanding.
- Handles byte/half/word sizing, store byte strobes, load sign/zero extension and misalignment detection.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CTRL_W, 10, control bus width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- memPc  in  32  PC of the instruction in MEM.
- memAluRes  in  32  effective address, or the ALU result for non-memory ops.
- memRegData2  in  32  store source data.
- memRd  in  5  destination register.
- memCtrlSig  in  10  control bits:
  - [0] regWrite, [1] memToReg, [2] memRead, [3] memWrite
  - [5:4] size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
  - [6] unsignedLoad
  - [9:7] passed to WB unchanged
- memStall  out  1  combinational; upstream pipeline registers hold while high.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_req_we  out  1  1 = store.
- dmem_addr  out  32  {memAluRes[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte strobes; 0 for loads.
- dmem_rsp_valid  in  1  response/ack; arrives at earliest one cycle after the request handshake.
- dmem_rsp_rdata  in  32  load data (aligned word).
- wbPc  out  32  registered.
- wbResult  out  32  registered.
- wbRd  out  5  registered.
- wbCtrlSig  out  10  registered; bit 0 already qualified (see below).
- wbValid  out  1  registered; 1 = real instruction in WB.
- wbMisalign  out  1  registered misaligned-access flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; dmem_req_valid=0.
  - All wb* outputs=0, including wbValid and wbMisalign.
- A memory op is memRead|memWrite. Bubble = memCtrlSig==0; a bubble gives wbValid=0.
- Misaligned:
  - Condition: half with addr[0]=1, or word with addr[1:0]!=0.
  - No request is issued and there is no stall.
  - Next edge: wbMisalign=1, wbValid=1, wbCtrlSig[0] forced 0.
- FSM states IDLE, REQ, WAIT:
  - IDLE, non-memory op or bubble: WB regs load the inputs (wbResult=memAluRes) at the next edge; memStall=0.
  - IDLE, aligned memory op: memStall=1; go to REQ; WB regs load a bubble (wbValid=0).
  - REQ: dmem_req_valid=1 with addr/we/wdata/wstrb stable; memStall=1. On dmem_req_ready go to WAIT. Hold valid until ready.
  - WAIT, no dmem_rsp_valid: memStall=1; WB loads a bubble.
  - WAIT, dmem_rsp_valid: memStall=0. WB regs load the instruction at this edge; next state IDLE. The upstream register advances on the same edge.
- Minimum latency with an immediate ready and response: 3 cycles from arrival to WB. Non-memory op: 1 cycle.
- Store strobes and data:
  - byte: wstrb=4'b0001<<addr[1:0], wdata={4{rd2[7:0]}}.
  - half: wstrb=4'b0011<<{addr[1],1'b0}, wdata={2{rd2[15:0]}}.
  - word: wstrb=4'hF, wdata=rd2.
- Load data:
  - shifted = rdata>>(8*addr[1:0]).
  - byte/half: sign-extended, or zero-extended when unsignedLoad=1.
  - wbResult is the extended load data.
- Stores: wbResult=memAluRes; completion still waits for dmem_rsp_valid (write ack).
- dmem_rsp_valid in IDLE or REQ is ignored.
- Reset mid-access:
  - The FSM returns to IDLE immediately and dmem_req_valid drops.
  - A late response after reset is ignored.
- Inputs are sampled only in IDLE. They must be held stable by upstream while memStall=1.

Test Plan:
- lw: addr 0x104, rdata 0xDEADBEEF, ready and rsp each 1 cycle later -> wbResult=0xDEADBEEF, wbValid=1, 3 cycles after arrival; memStall high 2 cycles.
- lb: addr 0x103, rdata 0x80FF1234 -> wbResult=0xFFFFFF80. lbu at the same address -> 0x00000080.
- sh: addr 0x202, rd2=0x0000ABCD -> dmem_wstrb=4'b1100, dmem_wdata=0xABCDABCD, dmem_req_we=1, dmem_addr=0x200.
- lw at addr 0x101 -> no dmem_req_valid, memStall=0, next cycle wbMisalign=1 with wbCtrlSig[0]=0.
- ready held low 4 cycles in REQ -> req_valid and outputs stable 4 cycles, memStall high throughout; stray rsp_valid in REQ has no effect.
- rst_n pulsed low while in WAIT -> req_valid=0, wb* all 0 immediately; subsequent rsp_valid ignored; the next ADD passes with 1-cycle latency.
